// File: rtl/sync_fifo_pkt.sv
// Synchronous packet FIFO: FWFT valid/ready read port, write-side commit/abort,
// automatic drop of packets that overflow, almost-full/almost-empty thresholds.
module sync_fifo_pkt #(
    parameter int FIFO_D   = 16,
    parameter int FIFO_W   = 32,
    parameter int AF_THR   = FIFO_D - 2,
    parameter int AE_THR   = 2,
    parameter int FIFO_ADR = $clog2(FIFO_D)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_we,
    input  logic [FIFO_W-1:0] fifo_wd,
    input  logic              fifo_wlast,
    input  logic              fifo_wabort,
    input  logic              fifo_fsh,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [FIFO_W-1:0] rd_data,
    output logic              rd_last,
    output logic              fifo_full,
    output logic              fifo_empt,
    output logic              fifo_afull,
    output logic              fifo_aempt,
    output logic              fifo_ovf,
    output logic              fifo_pkt_drop,
    output logic [FIFO_ADR:0] fifo_len,
    output logic [FIFO_ADR:0] fifo_wcnt,
    output logic [FIFO_ADR:0] fifo_pkt_cnt
);

    localparam int CW = FIFO_ADR + 1;
    localparam logic [CW-1:0]       C_DEPTH = CW'(FIFO_D);
    localparam logic [CW-1:0]       C_AF    = CW'(AF_THR);
    localparam logic [CW-1:0]       C_AE    = CW'(AE_THR);
    localparam logic [CW-1:0]       C_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]       C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADR-1:0] C_LAST  = FIFO_ADR'(FIFO_D - 1);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } wr_state_t;

    wr_state_t r_state;
    wr_state_t w_state_nxt;

    logic [FIFO_W:0]       r_mem [FIFO_D];
    logic [FIFO_ADR-1:0]   r_rptr, r_wptr, r_cptr;
    logic [CW-1:0]         r_wcnt, r_len, r_pkt_cnt;
    logic                  r_ovf, r_pkt_drop;

    logic [FIFO_ADR-1:0]   w_rptr_nxt, w_wptr_nxt, w_cptr_nxt;
    logic [CW-1:0]         w_wcnt_nxt, w_len_nxt, w_pkt_cnt_nxt, w_unc;
    logic [FIFO_W:0]       w_head;
    logic                  w_full, w_rd_vld, w_rd, w_rd_pkt_end;
    logic                  w_wacc, w_commit, w_discard, w_ovf_ev, w_drop_ev;

    // Wrapping increment; depth need not be a power of two.
    function automatic logic [FIFO_ADR-1:0] f_inc(input logic [FIFO_ADR-1:0] p);
        if (p == C_LAST) begin
            return {FIFO_ADR{1'b0}};
        end else begin
            return p + {{(FIFO_ADR-1){1'b0}}, 1'b1};
        end
    endfunction

    // Head view, handshake and occupancy flags derived from current state
    always_comb begin
        w_head       = r_mem[r_rptr];
        w_full       = (r_wcnt == C_DEPTH);
        w_rd_vld     = (r_len != C_ZERO);
        w_rd         = w_rd_vld & rd_rdy;
        w_rd_pkt_end = w_rd & w_head[FIFO_W];
        w_unc        = r_wcnt - r_len;
    end

    // Write-side decision: accept, overflow, abort or end-of-dropped-packet
    always_comb begin
        w_state_nxt = r_state;
        w_wacc      = 1'b0;
        w_ovf_ev    = 1'b0;
        w_discard   = 1'b0;
        w_drop_ev   = 1'b0;
        if (fifo_wabort) begin
            w_state_nxt = ST_PASS;
            w_discard   = 1'b1;
            w_drop_ev   = (w_unc != C_ZERO) | fifo_we;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (fifo_we & ~w_full) begin
                        w_wacc = 1'b1;
                    end else if (fifo_we) begin
                        w_ovf_ev = 1'b1;
                        // An overflowing beat that is also the last one ends the packet at once
                        if (fifo_wlast) begin
                            w_discard = 1'b1;
                            w_drop_ev = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_wacc = 1'b0;
                    end
                end
                ST_DROP: begin
                    if (fifo_we & fifo_wlast) begin
                        w_state_nxt = ST_PASS;
                        w_discard   = 1'b1;
                        w_drop_ev   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
                default: begin
                    w_state_nxt = ST_PASS;
                end
            endcase
        end
    end

    // Next pointers and counters; reads and writes in the same cycle net out
    always_comb begin
        w_commit   = w_wacc & fifo_wlast;
        w_rptr_nxt = w_rd ? f_inc(r_rptr) : r_rptr;
        w_wptr_nxt = r_wptr;
        w_cptr_nxt = r_cptr;
        if (w_discard) begin
            w_wptr_nxt = r_cptr;
        end else if (w_wacc) begin
            w_wptr_nxt = f_inc(r_wptr);
            if (fifo_wlast) begin
                w_cptr_nxt = f_inc(r_wptr);
            end else begin
                w_cptr_nxt = r_cptr;
            end
        end else begin
            w_wptr_nxt = r_wptr;
        end
        w_wcnt_nxt    = (w_discard ? r_len : (r_wcnt + (w_wacc ? C_ONE : C_ZERO)))
                        - (w_rd ? C_ONE : C_ZERO);
        w_len_nxt     = (w_commit ? (r_wcnt + C_ONE) : r_len) - (w_rd ? C_ONE : C_ZERO);
        w_pkt_cnt_nxt = r_pkt_cnt + (w_commit ? C_ONE : C_ZERO)
                        - (w_rd_pkt_end ? C_ONE : C_ZERO);
    end

    // Write-state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_PASS;
        end else if (fifo_fsh) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, counters and single-cycle event pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rptr     <= {FIFO_ADR{1'b0}};
            r_wptr     <= {FIFO_ADR{1'b0}};
            r_cptr     <= {FIFO_ADR{1'b0}};
            r_wcnt     <= C_ZERO;
            r_len      <= C_ZERO;
            r_pkt_cnt  <= C_ZERO;
            r_ovf      <= 1'b0;
            r_pkt_drop <= 1'b0;
        end else if (fifo_fsh) begin
            r_rptr     <= {FIFO_ADR{1'b0}};
            r_wptr     <= {FIFO_ADR{1'b0}};
            r_cptr     <= {FIFO_ADR{1'b0}};
            r_wcnt     <= C_ZERO;
            r_len      <= C_ZERO;
            r_pkt_cnt  <= C_ZERO;
            r_ovf      <= 1'b0;
            r_pkt_drop <= 1'b0;
        end else begin
            r_rptr     <= w_rptr_nxt;
            r_wptr     <= w_wptr_nxt;
            r_cptr     <= w_cptr_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_len      <= w_len_nxt;
            r_pkt_cnt  <= w_pkt_cnt_nxt;
            r_ovf      <= w_ovf_ev;
            r_pkt_drop <= w_drop_ev;
        end
    end

    // Storage array, deliberately left without reset
    always_ff @(posedge clk) begin
        if (w_wacc & ~fifo_fsh) begin
            r_mem[r_wptr] <= {fifo_wlast, fifo_wd};
        end
    end

    assign rd_vld        = w_rd_vld;
    assign rd_data       = w_rd_vld ? w_head[FIFO_W-1:0] : {FIFO_W{1'b0}};
    assign rd_last       = w_rd_vld & w_head[FIFO_W];
    assign fifo_full     = w_full;
    assign fifo_empt     = ~w_rd_vld;
    assign fifo_afull    = (r_wcnt >= C_AF);
    assign fifo_aempt    = (r_len <= C_AE);
    assign fifo_ovf      = r_ovf;
    assign fifo_pkt_drop = r_pkt_drop;
    assign fifo_len      = r_len;
    assign fifo_wcnt     = r_wcnt;
    assign fifo_pkt_cnt  = r_pkt_cnt;

endmodule
